frame_tile_writer: RTL and testbench
====================================

# frame_tile_writer

Write-port sequencer for the 330x330, 2-bit-per-pixel dual-port frame buffer. It accepts two kinds of drawing request: a full-screen clear and a single maze-tile fill on a 10x10 grid of 33x33-pixel tiles. It arbitrates between them and drives the frame buffer's write address, write enable and write data, one pixel per clock. It sits between the maze/robot-state logic (the requesters) and the frame buffer's write port. The VGA read side is untouched.

## Interface
- SCREEN_W, 330, frame width and height in pixels (square frame)
- TILE_PX, 33, tile edge in pixels
- GRID_N, 10, tiles per row/column; SCREEN_W must equal GRID_N*TILE_PX
- clk_W  input  1  write-domain clock; the only clock in the block
- reset_n  input  1  asynchronous, active-low reset
- clr_valid  input  1  clear request
- clr_color  input  2  fill colour for the clear
- clr_ready  output  1  clear request accepted this cycle when high together with clr_valid
- tile_valid  input  1  tile request
- tile_x, tile_y  input  4 each  tile column and row, 0..GRID_N-1
- tile_color  input  2  tile fill colour
- tile_ready  output  1  tile request accepted this cycle when high together with tile_valid
- w_addr  output  18  frame buffer write address
- w_data  output  2  frame buffer write data
- w_en  output  1  frame buffer write enable
- busy  output  1  a fill is in progress
- done  output  1  one-cycle pulse after the last pixel of a fill is written

## Operation
- The state machine has three states: IDLE, CLEAR and TILE.
- IDLE
  - clr_ready and tile_ready are both high.
  - If clr_valid is high, the clear is accepted. This holds even when tile_valid is also high: the clear has fixed priority, and tile_ready is driven low that cycle.
  - If only tile_valid is high, the tile request is accepted.
- Requests are latched on acceptance. The block then changes state on the next edge.
- CLEAR
  - Writes every pixel at addresses 0..SCREEN_W*SCREEN_W-1 (108899) in ascending order with the latched colour.
- TILE
  - Origin address = tile_y*TILE_PX*SCREEN_W + tile_x*TILE_PX. This is computed once at acceptance.
  - Pixels are written row-major: 33 pixels per row, then the row base advances by SCREEN_W, for 33 rows.
  - Addresses are generated with column/row counters plus an adder on the row base. There is no per-pixel multiplier.
- A tile_x or tile_y value of GRID_N or more is accepted but ignored: no writes, done pulses one cycle later, then back to IDLE.
- Both ready outputs are low in CLEAR and TILE. Requests arriving while busy are not queued; requesters hold valid until ready.
- After the final pixel of a fill, the block returns to IDLE and pulses done.

## Timing
- Reset values
  - w_en = 0, w_addr = 0, w_data = 0, busy = 0, done = 0.
  - clr_ready = 1 and tile_ready = 1 (combinational from IDLE).
- All datapath outputs are registered.
- Latency
  - The first w_en is asserted the cycle after acceptance.
  - A tile fill holds w_en high for exactly 1089 consecutive cycles.
  - A clear holds w_en high for exactly 108900 consecutive cycles.
- done is high in the cycle immediately after the last w_en cycle. In that same cycle busy is low and both ready outputs are high, so a new request may be accepted that cycle.
- busy is high from the cycle after acceptance through the last w_en cycle.
- Asserting reset_n low mid-fill aborts the fill immediately: w_en goes low asynchronously and no done pulse is produced. Pixels already written stay written.
- If clr_valid and tile_valid are high in the same IDLE cycle, the clear wins. The tile is accepted at the earliest on the done cycle of that clear.

## Configuration
- TILE_BORDER_EN defined
  - In TILE fills, pixels in a tile's first or last row or column are written as 2'b00, giving black grid lines.
  - Interior 31x31 pixels use tile_color.
  - The write count is unchanged at 1089.
- TILE_BORDER_EN undefined
  - All 1089 tile pixels use tile_color.
  - The border comparators are not built.
- TILE_BORDER_EN has no effect on CLEAR fills.

## Structure
- The shared package `frame_pkg` holds:
  - SCREEN_W, TILE_PX, GRID_N
  - FB_AW = 18 (frame buffer address width)
  - the 2-bit colour typedef `pixel_t`
  - the state enum {IDLE, CLEAR, TILE}
- One sub-module: `tile_addr_gen`. It holds the row/column counters and row-base accumulator, and produces the address, a last-pixel flag and a border flag. The same module serves CLEAR when configured with rows = cols = SCREEN_W and origin = 0.

## Test plan
- Tile request: tile_x=0, tile_y=0, colour 2'b01 → w_en high for 1089 cycles.
  - First address 0; address 32 is followed by 330; last address 32*330+32 = 10592.
  - done pulses once.
- Tile request: tile_x=9, tile_y=9, colour 2'b10 → first address 297*330+297 = 98307; last address 108899.
  - No address exceeds 108899.
- clr_valid and tile_valid high in the same cycle → only clr_ready is seen high with its valid.
  - 108900 writes of clr_color, then the tile is accepted on the done cycle and its fill starts the next cycle.
- With TILE_BORDER_EN defined, tile (3,2), colour 2'b11 → writes at addresses 66*330+99 and 98*330+131 carry 2'b00.
  - The write at address 67*330+100 carries 2'b11.
- reset_n pulled low 500 cycles into a clear → w_en drops at once with no done pulse.
  - After release, busy = 0 and both ready outputs = 1.
  - A new tile request then completes normally.
- Tile request with tile_x=10 → zero w_en cycles; done pulses the cycle after acceptance.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared constants, pixel type and sequencer states for the frame buffer write path.
package frame_pkg;

  localparam int unsigned SCREEN_W = 330;
  localparam int unsigned TILE_PX  = 33;
  localparam int unsigned GRID_N   = 10;
  localparam int unsigned FB_AW    = 18;
  localparam int unsigned CNT_W    = 9;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, CLEAR, TILE} state_t;

  // Top-left pixel address of a tile; evaluated once when the request is accepted.
  function automatic logic [FB_AW-1:0] tile_origin(input logic [3:0] tx, input logic [3:0] ty);
    return FB_AW'(ty) * FB_AW'(TILE_PX * SCREEN_W) + FB_AW'(tx) * FB_AW'(TILE_PX);
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Square-region address walker: column/row counters plus a row-base accumulator.
// With TILE_BORDER_EN defined it also flags edge pixels of the region.
module tile_addr_gen
  import frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  input  logic [FB_AW-1:0] origin,
  input  logic [CNT_W-1:0] size,
  output logic [FB_AW-1:0] addr,
  output logic             last_c,
  output logic             border_nxt_c
);

  logic [CNT_W-1:0] col_q, row_q, size_q;
  logic [CNT_W-1:0] col_n, row_n, size_n;
  logic [FB_AW-1:0] base_q, base_n, addr_n;

  // Next pixel position: restart on load, step along the row, wrap to the next row base.
  always_comb begin
    col_n  = col_q;
    row_n  = row_q;
    size_n = size_q;
    base_n = base_q;
    addr_n = addr;
    if (load) begin
      col_n  = '0;
      row_n  = '0;
      size_n = size;
      base_n = origin;
      addr_n = origin;
    end else if (adv) begin
      if (col_q == size_q - CNT_W'(1)) begin
        col_n  = '0;
        row_n  = row_q + CNT_W'(1);
        base_n = base_q + FB_AW'(SCREEN_W);
        addr_n = base_q + FB_AW'(SCREEN_W);
      end else begin
        col_n  = col_q + CNT_W'(1);
        addr_n = addr + FB_AW'(1);
      end
    end
  end

  assign last_c = (col_q == size_q - CNT_W'(1)) && (row_q == size_q - CNT_W'(1));

`ifdef TILE_BORDER_EN
  logic [CNT_W-1:0] lim_n;
  assign lim_n        = size_n - CNT_W'(1);
  assign border_nxt_c = (col_n == '0) || (col_n == lim_n) || (row_n == '0) || (row_n == lim_n);
`else
  assign border_nxt_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      size_q <= '0;
      base_q <= '0;
      addr   <= '0;
    end else begin
      col_q  <= col_n;
      row_q  <= row_n;
      size_q <= size_n;
      base_q <= base_n;
      addr   <= addr_n;
    end
  end

endmodule

// File: rtl/frame_tile_writer.sv
// Frame buffer write-port sequencer: full-screen clear (priority) or single tile fill.
// TILE_BORDER_EN: when defined, tile edge pixels are written black.
module frame_tile_writer
  import frame_pkg::*;
(
  input  logic        clk_W,
  input  logic        reset_n,
  input  logic        clr_valid,
  input  logic [1:0]  clr_color,
  output logic        clr_ready,
  input  logic        tile_valid,
  input  logic [3:0]  tile_x,
  input  logic [3:0]  tile_y,
  input  logic [1:0]  tile_color,
  output logic        tile_ready,
  output logic [17:0] w_addr,
  output logic [1:0]  w_data,
  output logic        w_en,
  output logic        busy,
  output logic        done
);

  state_t           state_q, state_n;
  pixel_t           color_q, color_n, w_data_n;
  logic             w_en_n, busy_n, done_n;
  logic             load, adv, tile_ok;
  logic [FB_AW-1:0] origin;
  logic [CNT_W-1:0] size;
  logic             last_c, border_nxt_c;

  assign tile_ok = (tile_x < 4'(GRID_N)) && (tile_y < 4'(GRID_N));

  tile_addr_gen u_gen (
    .clk          (clk_W),
    .rst_n        (reset_n),
    .load         (load),
    .adv          (adv),
    .origin       (origin),
    .size         (size),
    .addr         (w_addr),
    .last_c       (last_c),
    .border_nxt_c (border_nxt_c)
  );

  always_ff @(posedge clk_W or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Arbitration, next state and next values of the registered write-port outputs.
  always_comb begin
    state_n    = state_q;
    clr_ready  = 1'b0;
    tile_ready = 1'b0;
    load       = 1'b0;
    adv        = 1'b0;
    origin     = '0;
    size       = CNT_W'(TILE_PX);
    color_n    = color_q;
    w_en_n     = 1'b0;
    w_data_n   = w_data;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_ready  = 1'b1;
        tile_ready = !clr_valid;
        if (clr_valid) begin
          load     = 1'b1;
          size     = CNT_W'(SCREEN_W);
          color_n  = clr_color;
          w_en_n   = 1'b1;
          w_data_n = clr_color;
          busy_n   = 1'b1;
          state_n  = CLEAR;
        end else if (tile_valid) begin
          if (tile_ok) begin
            load     = 1'b1;
            origin   = tile_origin(tile_x, tile_y);
            color_n  = tile_color;
            w_en_n   = 1'b1;
            w_data_n = border_nxt_c ? pixel_t'(0) : tile_color;
            busy_n   = 1'b1;
            state_n  = TILE;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      CLEAR, TILE: begin
        if (last_c) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          adv      = 1'b1;
          w_en_n   = 1'b1;
          busy_n   = 1'b1;
          w_data_n = (state_q == TILE && border_nxt_c) ? pixel_t'(0) : color_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_W or negedge reset_n) begin
    if (!reset_n) begin
      color_q <= '0;
      w_en    <= 1'b0;
      w_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      color_q <= color_n;
      w_en    <= w_en_n;
      w_data  <= w_data_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_frame_tile_writer.sv
// Scoreboard bench for frame_tile_writer: randomized tile requests, clear priority, reset abort.
module tb_frame_tile_writer;

  localparam int SW  = 330;
  localparam int TP  = 33;
  localparam int GN  = 10;
  localparam int NPX = SW * SW;

  typedef struct {
    bit is_done;
    int addr;
    int data;
  } ev_t;

  ev_t sbq[$];
  ev_t mon_e;

  logic        clk_W = 1'b0;
  logic        reset_n;
  logic        clr_valid, tile_valid;
  logic [1:0]  clr_color, tile_color;
  logic [3:0]  tile_x, tile_y;
  logic        clr_ready, tile_ready;
  logic [17:0] w_addr;
  logic [1:0]  w_data;
  logic        w_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_wen = 1'b0;

  always #5 clk_W = ~clk_W;

  frame_tile_writer dut (
    .clk_W      (clk_W),
    .reset_n    (reset_n),
    .clr_valid  (clr_valid),
    .clr_color  (clr_color),
    .clr_ready  (clr_ready),
    .tile_valid (tile_valid),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .tile_color (tile_color),
    .tile_ready (tile_ready),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .w_en       (w_en),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every pixel of the tile square in row-major order, then done.
  task automatic push_tile(input int x, input int y, input int color);
    ev_t e;
    if (x < GN && y < GN) begin
      for (int r = 0; r < TP; r++) begin
        for (int c = 0; c < TP; c++) begin
          e.is_done = 1'b0;
          e.addr    = (y * TP + r) * SW + x * TP + c;
          e.data    = color;
`ifdef TILE_BORDER_EN
          if (r == 0 || r == TP - 1 || c == 0 || c == TP - 1) e.data = 0;
`endif
          sbq.push_back(e);
        end
      end
    end
    e.is_done = 1'b1;
    e.addr    = 0;
    e.data    = 0;
    sbq.push_back(e);
  endtask

  task automatic push_clear(input int color);
    ev_t e;
    for (int a = 0; a < NPX; a++) begin
      e.is_done = 1'b0;
      e.addr    = a;
      e.data    = color;
      sbq.push_back(e);
    end
    e.is_done = 1'b1;
    e.addr    = 0;
    e.data    = 0;
    sbq.push_back(e);
  endtask

  // Monitor: every w_en or done cycle consumes one expected event; a write stream must not break.
  always @(negedge clk_W) begin
    if (reset_n !== 1'b1) begin
      prev_wen = 1'b0;
    end else begin
      if (w_en === 1'b1 || done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_event", 32'(sbq.size()), 32'd1);
        end else begin
          mon_e = sbq.pop_front();
          chk("event_kind", 32'(done), 32'(mon_e.is_done));
          if (!mon_e.is_done) begin
            chk("w_addr", 32'(w_addr), 32'(mon_e.addr));
            chk("w_data", 32'(w_data), 32'(mon_e.data));
          end
        end
        if (w_en === 1'b1) begin
          chk("addr_range", 32'(w_addr < 18'(NPX)), 32'd1);
          chk("ready_low_busy", 32'({clr_ready, tile_ready}), 32'd0);
        end else begin
          chk("clr_ready_on_done", 32'(clr_ready), 32'd1);
        end
      end else if (prev_wen) begin
        chk("stream_gap", 32'(w_en | done), 32'd1);
      end
      chk("busy_vs_wen", 32'(busy), 32'(w_en));
      prev_wen = (w_en === 1'b1);
    end
  end

  task automatic send_tile(input int x, input int y, input int color);
    bit acc = 1'b0;
    @(posedge clk_W); #1;
    tile_x     = 4'(x);
    tile_y     = 4'(y);
    tile_color = 2'(color);
    tile_valid = 1'b1;
    for (int i = 0; i < 150000 && !acc; i++) begin
      @(negedge clk_W);
      if (tile_ready === 1'b1) begin
        acc = 1'b1;
        push_tile(x, y, color);
      end
    end
    chk("tile_accept", 32'(acc), 32'd1);
    @(posedge clk_W); #1;
    tile_valid = 1'b0;
    @(negedge clk_W);
    if (x < GN && y < GN) begin
      chk("first_wen", 32'(w_en), 32'd1);
    end else begin
      chk("invalid_done", 32'(done), 32'd1);
      chk("invalid_no_wen", 32'(w_en), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 120000 && sbq.size() != 0; i++) @(negedge clk_W);
    chk("drain", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk_W);
  endtask

  initial begin
    reset_n    = 1'b0;
    clr_valid  = 1'b0;
    tile_valid = 1'b0;
    clr_color  = '0;
    tile_color = '0;
    tile_x     = '0;
    tile_y     = '0;
    repeat (3) @(negedge clk_W);
    chk("rst_w_en", 32'(w_en), 32'd0);
    chk("rst_w_addr", 32'(w_addr), 32'd0);
    chk("rst_w_data", 32'(w_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'({clr_ready, tile_ready}), 32'd3);
    @(posedge clk_W); #1;
    reset_n = 1'b1;

    send_tile(0, 0, 1);
    drain();
    send_tile(9, 9, 2);
    drain();
    send_tile(3, 2, 3);
    drain();
    send_tile(10, 0, 1);
    drain();
    send_tile(0, 12, 2);
    drain();

    // Simultaneous clear and tile: clear wins, tile is taken on the clear's done cycle.
    @(posedge clk_W); #1;
    clr_valid  = 1'b1;
    clr_color  = 2'd2;
    tile_valid = 1'b1;
    tile_x     = 4'd4;
    tile_y     = 4'd5;
    tile_color = 2'd1;
    @(negedge clk_W);
    chk("both_clr_ready", 32'(clr_ready), 32'd1);
    chk("both_tile_ready", 32'(tile_ready), 32'd0);
    push_clear(2);
    @(posedge clk_W); #1;
    clr_valid = 1'b0;
    begin
      bit acc = 1'b0;
      for (int i = 0; i < 115000 && !acc; i++) begin
        @(negedge clk_W);
        if (tile_ready === 1'b1) begin
          acc = 1'b1;
          chk("tile_on_done", 32'(done), 32'd1);
          push_tile(4, 5, 1);
        end
      end
      chk("tile_after_clear", 32'(acc), 32'd1);
    end
    @(posedge clk_W); #1;
    tile_valid = 1'b0;
    @(negedge clk_W);
    chk("tile_after_clear_wen", 32'(w_en), 32'd1);
    drain();

    // Reset 500 cycles into a clear aborts with no done pulse.
    @(posedge clk_W); #1;
    clr_valid = 1'b1;
    clr_color = 2'd3;
    @(negedge clk_W);
    chk("clr2_ready", 32'(clr_ready), 32'd1);
    push_clear(3);
    @(posedge clk_W); #1;
    clr_valid = 1'b0;
    repeat (500) @(negedge clk_W);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_wen", 32'(w_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    sbq.delete();
    repeat (3) begin
      @(negedge clk_W);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    @(posedge clk_W); #1;
    reset_n = 1'b1;
    @(negedge clk_W);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'({clr_ready, tile_ready}), 32'd3);
    chk("post_rst_done", 32'(done), 32'd0);
    send_tile(1, 7, 2);
    drain();

    // Randomized tile stream, including out-of-range coordinates and back-to-back requests.
    for (int k = 0; k < 10; k++) begin
      send_tile(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk_W);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
